// File: rtl/copperv_bus_pkg.sv
// Shared types for the copperv memory arbiter: FSM states, requester indices, default widths.
// The rotation helper is used by the round-robin grant and by nothing else.
package copperv_bus_pkg;

  localparam int DEF_BUS_WIDTH      = 32;
  localparam int DEF_BUS_RESP_WIDTH = 1;
  localparam int NUM_REQ            = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DLVR = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REQ_IR = 2'd0,
    REQ_DR = 2'd1,
    REQ_DW = 2'd2
  } req_idx_e;

  // ir -> dr -> dw -> ir; any out-of-range index restarts at ir
  function automatic req_idx_e rr_next(input req_idx_e idx);
    req_idx_e nxt;
    case (idx)
      REQ_IR:  nxt = REQ_DR;
      REQ_DR:  nxt = REQ_DW;
      default: nxt = REQ_IR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/copperv_mem_arbiter_if.sv
// Core-side (ir/dr/dw) and memory-side channels of the arbiter in one bundle.
// master = environment (core masters plus memory), slave = the arbiter.
interface copperv_mem_arbiter_if #(
  parameter int BUS_WIDTH      = 32,
  parameter int BUS_RESP_WIDTH = 1
);
  logic                      bus_ir_addr_valid;
  logic                      bus_ir_addr_ready;
  logic [BUS_WIDTH-1:0]      bus_ir_addr_bits;
  logic                      bus_ir_data_valid;
  logic                      bus_ir_data_ready;
  logic [BUS_WIDTH-1:0]      bus_ir_data_bits;

  logic                      bus_dr_addr_valid;
  logic                      bus_dr_addr_ready;
  logic [BUS_WIDTH-1:0]      bus_dr_addr_bits;
  logic                      bus_dr_data_valid;
  logic                      bus_dr_data_ready;
  logic [BUS_WIDTH-1:0]      bus_dr_data_bits;

  logic                      bus_dw_req_valid;
  logic                      bus_dw_req_ready;
  logic [BUS_WIDTH-1:0]      bus_dw_req_bits_addr;
  logic [BUS_WIDTH-1:0]      bus_dw_req_bits_data;
  logic [BUS_WIDTH/8-1:0]    bus_dw_req_bits_strobe;
  logic                      bus_dw_resp_valid;
  logic                      bus_dw_resp_ready;
  logic [BUS_RESP_WIDTH-1:0] bus_dw_resp_bits;

  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [BUS_WIDTH-1:0]      mem_req_addr;
  logic [BUS_WIDTH-1:0]      mem_req_data;
  logic [BUS_WIDTH/8-1:0]    mem_req_strobe;
  logic                      mem_req_write;
  logic                      mem_resp_valid;
  logic                      mem_resp_ready;
  logic [BUS_WIDTH-1:0]      mem_resp_data;
  logic [BUS_RESP_WIDTH-1:0] mem_resp_status;

  modport master (
    output bus_ir_addr_valid, bus_ir_addr_bits, bus_ir_data_ready,
    input  bus_ir_addr_ready, bus_ir_data_valid, bus_ir_data_bits,
    output bus_dr_addr_valid, bus_dr_addr_bits, bus_dr_data_ready,
    input  bus_dr_addr_ready, bus_dr_data_valid, bus_dr_data_bits,
    output bus_dw_req_valid, bus_dw_req_bits_addr, bus_dw_req_bits_data,
    output bus_dw_req_bits_strobe, bus_dw_resp_ready,
    input  bus_dw_req_ready, bus_dw_resp_valid, bus_dw_resp_bits,
    input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_strobe, mem_req_write,
    output mem_req_ready,
    output mem_resp_valid, mem_resp_data, mem_resp_status,
    input  mem_resp_ready
  );

  modport slave (
    input  bus_ir_addr_valid, bus_ir_addr_bits, bus_ir_data_ready,
    output bus_ir_addr_ready, bus_ir_data_valid, bus_ir_data_bits,
    input  bus_dr_addr_valid, bus_dr_addr_bits, bus_dr_data_ready,
    output bus_dr_addr_ready, bus_dr_data_valid, bus_dr_data_bits,
    input  bus_dw_req_valid, bus_dw_req_bits_addr, bus_dw_req_bits_data,
    input  bus_dw_req_bits_strobe, bus_dw_resp_ready,
    output bus_dw_req_ready, bus_dw_resp_valid, bus_dw_resp_bits,
    output mem_req_valid, mem_req_addr, mem_req_data, mem_req_strobe, mem_req_write,
    input  mem_req_ready,
    input  mem_resp_valid, mem_resp_data, mem_resp_status,
    output mem_resp_ready
  );

endinterface

// File: rtl/copperv_rr_arb.sv
// Combinational 3-way round-robin grant: search starts at the requester after last_i.
// No state here; the parent owns and updates the pointer.
module copperv_rr_arb
  import copperv_bus_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  req_idx_e           last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output req_idx_e           grant_idx_o
);

  req_idx_e cand;
  logic     found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = last_i;
    found       = 1'b0;
    cand        = rr_next(last_i);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
        found         = 1'b1;
      end
      cand = rr_next(cand);
    end
  end

endmodule

// File: rtl/copperv_mem_arbiter.sv
// Shares one memory request/response port between ir, dr and dw; one transaction in flight.
// Minimum 4 cycles from address handshake to next arbitration; any stall extends its state.
module copperv_mem_arbiter
  import copperv_bus_pkg::*;
#(
  parameter int BUS_WIDTH      = DEF_BUS_WIDTH,
  parameter int BUS_RESP_WIDTH = DEF_BUS_RESP_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  copperv_mem_arbiter_if.slave bus
);

  localparam int STRB_W = BUS_WIDTH / 8;

  state_e               state_q, state_d;
  req_idx_e             gnt_idx_q, gnt_idx_d;
  req_idx_e             rr_last_q, rr_last_d;
  logic [BUS_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic [STRB_W-1:0]    strobe_q, strobe_d;
  logic [BUS_WIDTH-1:0] resp_q, resp_d;

  logic [NUM_REQ-1:0]   req_vec;
  logic [NUM_REQ-1:0]   gnt_oh;
  req_idx_e             gnt_idx;
  logic                 arb_hs;
  logic                 dlvr_rdy;
  logic                 is_write;

  assign req_vec  = {bus.bus_dw_req_valid, bus.bus_dr_addr_valid, bus.bus_ir_addr_valid};
  assign is_write = (gnt_idx_q == REQ_DW);

  copperv_rr_arb u_rr_arb (
    .req_i       (req_vec),
    .last_i      (rr_last_q),
    .grant_o     (gnt_oh),
    .grant_idx_o (gnt_idx)
  );

  // Readies are combinational from valid, so they are also masked while reset is held
  assign arb_hs = (state_q == S_IDLE) && reset && (|req_vec);

  always_comb begin
    case (gnt_idx_q)
      REQ_IR:  dlvr_rdy = bus.bus_ir_data_ready;
      REQ_DR:  dlvr_rdy = bus.bus_dr_data_ready;
      default: dlvr_rdy = bus.bus_dw_resp_ready;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arb_hs)             state_d = S_REQ;
      S_REQ:   if (bus.mem_req_ready)  state_d = S_WAIT;
      S_WAIT:  if (bus.mem_resp_valid) state_d = S_DLVR;
      S_DLVR:  if (dlvr_rdy)           state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_idx_d = gnt_idx_q;
    rr_last_d = rr_last_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strobe_d  = strobe_q;
    resp_d    = resp_q;
    if (arb_hs) begin
      gnt_idx_d = gnt_idx;
      data_d    = '0;
      strobe_d  = '0;
      case (gnt_idx)
        REQ_IR:  addr_d = bus.bus_ir_addr_bits;
        REQ_DR:  addr_d = bus.bus_dr_addr_bits;
        default: begin
          addr_d   = bus.bus_dw_req_bits_addr;
          data_d   = bus.bus_dw_req_bits_data;
          strobe_d = bus.bus_dw_req_bits_strobe;
        end
      endcase
    end
    if (state_q == S_WAIT && bus.mem_resp_valid) begin
      resp_d = is_write ? BUS_WIDTH'(bus.mem_resp_status) : bus.mem_resp_data;
    end
    if (state_q == S_DLVR && dlvr_rdy) begin
      rr_last_d = gnt_idx_q;
    end
  end

  // Pointer starts at dw so ir wins the first arbitration after reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gnt_idx_q <= REQ_IR;
      rr_last_q <= REQ_DW;
      addr_q    <= '0;
      data_q    <= '0;
      strobe_q  <= '0;
      resp_q    <= '0;
    end else begin
      gnt_idx_q <= gnt_idx_d;
      rr_last_q <= rr_last_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strobe_q  <= strobe_d;
      resp_q    <= resp_d;
    end
  end

  always_comb begin
    bus.bus_ir_addr_ready = 1'b0;
    bus.bus_dr_addr_ready = 1'b0;
    bus.bus_dw_req_ready  = 1'b0;
    bus.bus_ir_data_valid = 1'b0;
    bus.bus_ir_data_bits  = '0;
    bus.bus_dr_data_valid = 1'b0;
    bus.bus_dr_data_bits  = '0;
    bus.bus_dw_resp_valid = 1'b0;
    bus.bus_dw_resp_bits  = '0;
    bus.mem_req_valid     = 1'b0;
    bus.mem_req_addr      = '0;
    bus.mem_req_data      = '0;
    bus.mem_req_strobe    = '0;
    bus.mem_req_write     = 1'b0;
    bus.mem_resp_ready    = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.bus_ir_addr_ready = gnt_oh[REQ_IR] & reset;
        bus.bus_dr_addr_ready = gnt_oh[REQ_DR] & reset;
        bus.bus_dw_req_ready  = gnt_oh[REQ_DW] & reset;
      end
      S_REQ: begin
        bus.mem_req_valid  = 1'b1;
        bus.mem_req_addr   = addr_q;
        bus.mem_req_write  = is_write;
        bus.mem_req_data   = data_q;
        bus.mem_req_strobe = strobe_q;
      end
      S_WAIT: begin
        bus.mem_resp_ready = 1'b1;
      end
      S_DLVR: begin
        case (gnt_idx_q)
          REQ_IR: begin
            bus.bus_ir_data_valid = 1'b1;
            bus.bus_ir_data_bits  = resp_q;
          end
          REQ_DR: begin
            bus.bus_dr_data_valid = 1'b1;
            bus.bus_dr_data_bits  = resp_q;
          end
          default: begin
            bus.bus_dw_resp_valid = 1'b1;
            bus.bus_dw_resp_bits  = resp_q[BUS_RESP_WIDTH-1:0];
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: doc/copperv_mem_arbiter.md
# copperv_mem_arbiter

Shares one single-ported memory interface between the core's three bus masters: instruction read (ir), data read (dr) and data write (dw). It sits between the core and a unified memory model or SRAM controller. One transaction is outstanding at a time, and grants are round-robin. Each requester sees its usual ready/valid channel pair, and memory sees one request/response channel pair.

## Interface
- BUS_WIDTH, 32, address/data width
- BUS_RESP_WIDTH, 1, write-response status width
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- bus_ir_addr_valid / bus_ir_addr_ready  in/out  1  ir address handshake
- bus_ir_addr_bits  in  BUS_WIDTH  fetch address
- bus_ir_data_valid / bus_ir_data_ready  out/in  1  ir data handshake
- bus_ir_data_bits  out  BUS_WIDTH  fetched word
- bus_dr_addr_valid, bus_dr_addr_ready, bus_dr_addr_bits, bus_dr_data_valid, bus_dr_data_ready, bus_dr_data_bits: same directions and widths as the ir set, for data reads
- bus_dw_req_valid / bus_dw_req_ready  in/out  1  write request handshake
- bus_dw_req_bits_addr, bus_dw_req_bits_data  in  BUS_WIDTH  write address/data
- bus_dw_req_bits_strobe  in  BUS_WIDTH/8  byte enables
- bus_dw_resp_valid / bus_dw_resp_ready  out/in  1  write response handshake
- bus_dw_resp_bits  out  BUS_RESP_WIDTH  write status
- mem_req_valid / mem_req_ready  out/in  1  memory request handshake
- mem_req_addr, mem_req_data  out  BUS_WIDTH  request address/data
- mem_req_strobe  out  BUS_WIDTH/8  byte enables
- mem_req_write  out  1  1 = write, 0 = read
- mem_resp_valid / mem_resp_ready  in/out  1  memory response handshake
- mem_resp_data  in  BUS_WIDTH  read data
- mem_resp_status  in  BUS_RESP_WIDTH  write status

## Operation
The FSM has four states, IDLE, REQ, WAIT and DLVR. All transitions occur on the clock edge.

- **IDLE**
  - The arbiter picks a winner among the asserted bus_ir_addr_valid, bus_dr_addr_valid and bus_dw_req_valid.
  - Priority rotates, starting from the requester after the last grant; the rotation order is ir → dr → dw → ir.
  - The winner's addr/req ready is asserted combinationally in the same cycle. This is the only valid→ready combinational path.
  - On the handshake the arbiter latches the address. For dw it also latches data and strobe.
  - It records the grant index and goes to REQ.
  - With no valid asserted, it stays in IDLE.
- **REQ**
  - mem_req_valid is 1, driven from the latched fields. These are held stable until mem_req_ready.
  - For a read: mem_req_write=0, mem_req_data=0, mem_req_strobe=0.
  - For a write: mem_req_write=1, with the latched data and strobe.
  - On handshake → WAIT.
- **WAIT**
  - mem_resp_ready is 1.
  - On mem_resp_valid the arbiter captures mem_resp_data (for ir/dr) or mem_resp_status (for dw) into the response register → DLVR.
- **DLVR**
  - The granted requester's data_valid (or bus_dw_resp_valid) is 1, with bits taken from the response register.
  - When the requester asserts the matching ready: round-robin pointer := grant index → IDLE.
- Non-granted requesters see ready=0 and valid=0 throughout. Their valids may stay asserted and are not lost.
- Requesters must hold valid and bits until their ready is asserted; the arbiter does not buffer unaccepted requests.

## Timing
- **Reset (asserted, asynchronous)**
  - FSM → IDLE.
  - All ready/valid outputs are 0; all bits outputs are 0.
  - Round-robin pointer = dw, so ir holds the highest priority on the first arbitration.
- **Reset mid-transaction:** the transaction is abandoned with no response delivered. Memory must be reset together with the arbiter.
- **Minimum latency**, with memory ready and responding at the earliest point:
  - cycle 0: addr handshake.
  - cycle 1: mem_req_valid.
  - cycle 2: mem_resp accepted.
  - cycle 3: requester data_valid.
  - cycle 4: next IDLE arbitration.
- Backpressure at any stage extends that state by exactly the stall cycles.
- A dw response has the same timing as a read.

## Structure
- **Shared package (copperv_bus_pkg):**
  - state encoding: IDLE, REQ, WAIT, DLVR
  - requester indices: REQ_IR=0, REQ_DR=1, REQ_DW=2
  - default BUS_WIDTH / BUS_RESP_WIDTH
- **Sub-module copperv_rr_arb:** a purely combinational 3-way round-robin grant.
  - inputs: req[2:0], last[1:0]
  - outputs: one-hot grant[2:0], grant index
  - pointer update is done in the parent

## Test plan
- **Reset holds:** reset low with all valids high → every ready/valid output is 0. After reset release, ir is granted first.
- **Single read:** ir requests addr 0x100; memory is always ready and returns 0xDEADBEEF one cycle after the request → bus_ir_data_valid at cycle 3 with 0xDEADBEEF, and bus_ir_addr_ready only at cycle 0.
- **Write:** dw writes addr 0x200, data 0x12345678, strobe 0x3 → memory sees write=1 with those exact fields. mem_resp_status=1 → bus_dw_resp_bits=1.
- **All three contending continuously:** grant order is ir, dr, dw, ir, dr, dw. No requester is served twice before the others are served once.
- **Backpressure:** mem_req_ready held low for 5 cycles, then bus_dr_data_ready held low for 3 cycles → fields stay stable throughout, and exactly one response is delivered.
- **Reset mid-WAIT:** reset asserted while in WAIT → outputs go to 0 immediately. After release, the dropped requester re-requests and completes normally.
